// File: rtl/multi_source_arbiter_pkg.sv
// Shared constants and helpers for the multi-source arbitrated register.
package multi_src_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // True when two or more bits of the (zero-extended) request vector are set
    function automatic logic more_than_one(input logic [15:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) cnt++;
        end
        return (cnt > 1);
    endfunction

endpackage

// File: rtl/multi_source_arbiter_rr_pick.sv
// Combinational winner selection: first set request at or above ptr, wrapping.
// The request vector is doubled so the wrap-around search becomes a plain
// lowest-bit priority encode; the lower copy is masked below ptr.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic           found;

    // Build the masked double-width vector and encode its lowest set bit
    always_comb begin
        mask   = '0;
        dbl    = '0;
        found  = 1'b0;
        winner = '0;
        any    = |req;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & mask};
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found  = 1'b1;
                winner = PTR_W'(i % N);
            end
        end
    end

endmodule

// File: rtl/multi_source_arbiter.sv
// N-source arbitrated register: one winner per cycle drives a single output
// register, and cycles with several requesters are counted as contention.
module multi_source_arbiter
    import multi_src_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        req,
    input  logic [N_SRC*DATA_W-1:0] data,
    input  logic                    clr_cnt,
    output logic [DATA_W-1:0]       out_q,
    output logic                    out_valid,
    output logic [N_SRC-1:0]        gnt,
    output logic                    conflict,
    output logic [CNT_W-1:0]        conflict_cnt
);

    localparam int PTR_W = $clog2(N_SRC);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] pick_ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] ptr_next;
    logic             any;
    logic             multi;

    // Fixed priority is round robin with the search always starting at zero
    assign pick_ptr = (MODE == MODE_RR) ? ptr : '0;
    assign multi    = more_than_one(16'(req));
    assign ptr_next = (winner == PTR_W'(N_SRC - 1)) ? '0 : winner + 1'b1;

    rr_pick #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner),
        .any    (any)
    );

    // Output register, grant, pointer and contention pulse; reset wins everything
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
            gnt       <= '0;
            conflict  <= 1'b0;
            ptr       <= '0;
        end else begin
            conflict <= multi;
            if (any) begin
                out_q     <= data[int'(winner) * DATA_W +: DATA_W];
                gnt       <= N_SRC'(1) << winner;
                out_valid <= 1'b1;
                if (MODE == MODE_RR) ptr <= ptr_next;
            end else begin
                gnt       <= '0;
                out_valid <= 1'b0;
            end
        end
    end

    // Saturating contention counter; an explicit clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            conflict_cnt <= '0;
        end else if (multi && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_source_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus,
// a behavioural model queues expected results, and they are popped after each edge.
module tb_multi_source_arbiter;
    import multi_src_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] out_q;
        logic          valid;
        logic [N-1:0]  gnt;
        logic          conflict;
        logic [CW-1:0] cnt;
        logic [1:0]    ptr;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic            clr_cnt;

    logic [DW-1:0] out_q_rr, out_q_fx;
    logic          valid_rr, valid_fx;
    logic [N-1:0]  gnt_rr, gnt_fx;
    logic          conf_rr, conf_fx;
    logic [CW-1:0] cnt_rr, cnt_fx;

    exp_t m_rr, m_fx;
    exp_t q_rr[$];
    exp_t q_fx[$];

    int n_checks;
    int n_fail;

    logic [N-1:0] rot_gnt [4];
    logic [DW-1:0] rot_out [4];

    multi_source_arbiter #(.N_SRC(N), .DATA_W(DW), .MODE(MODE_RR), .CNT_W(CW)) dut_rr (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data         (data),
        .clr_cnt      (clr_cnt),
        .out_q        (out_q_rr),
        .out_valid    (valid_rr),
        .gnt          (gnt_rr),
        .conflict     (conf_rr),
        .conflict_cnt (cnt_rr)
    );

    multi_source_arbiter #(.N_SRC(N), .DATA_W(DW), .MODE(MODE_FIXED), .CNT_W(CW)) dut_fx (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data         (data),
        .clr_cnt      (clr_cnt),
        .out_q        (out_q_fx),
        .out_valid    (valid_fx),
        .gnt          (gnt_fx),
        .conflict     (conf_fx),
        .conflict_cnt (cnt_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural next-state model: scans from the start index one source at a time
    function automatic exp_t modelStep(input exp_t s, input logic r, input logic [N-1:0] q,
                                       input logic [N*DW-1:0] d, input logic c, input bit rr);
        exp_t n;
        int   w;
        int   start;
        n = s;
        if (r) begin
            n = '0;
            return n;
        end
        n.conflict = more_than_one(16'(q));
        if (q != '0) begin
            w = -1;
            start = rr ? int'(s.ptr) : 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (start + k) % N;
                if (w < 0 && q[idx]) w = idx;
            end
            n.out_q = d[w * DW +: DW];
            n.gnt   = N'(1) << w;
            n.valid = 1'b1;
            if (rr) n.ptr = 2'((w + 1) % N);
        end else begin
            n.gnt   = '0;
            n.valid = 1'b0;
        end
        if (c) n.cnt = '0;
        else if (n.conflict && s.cnt != {CW{1'b1}}) n.cnt = s.cnt + 1'b1;
        return n;
    endfunction

    task automatic compareScoreboard();
        exp_t e;
        checkOutput("sb_depth_rr", 32'(q_rr.size()), 32'd1);
        checkOutput("sb_depth_fx", 32'(q_fx.size()), 32'd1);
        if (q_rr.size() > 0) begin
            e = q_rr.pop_front();
            checkOutput("rr_out_q", 32'(out_q_rr), 32'(e.out_q));
            checkOutput("rr_out_q_known", 32'($isunknown(out_q_rr)), 32'd0);
            checkOutput("rr_valid", 32'(valid_rr), 32'(e.valid));
            checkOutput("rr_gnt", 32'(gnt_rr), 32'(e.gnt));
            checkOutput("rr_conflict", 32'(conf_rr), 32'(e.conflict));
            checkOutput("rr_cnt", 32'(cnt_rr), 32'(e.cnt));
            checkOutput("rr_ptr", 32'(dut_rr.ptr), 32'(e.ptr));
        end
        if (q_fx.size() > 0) begin
            e = q_fx.pop_front();
            checkOutput("fx_out_q", 32'(out_q_fx), 32'(e.out_q));
            checkOutput("fx_out_q_known", 32'($isunknown(out_q_fx)), 32'd0);
            checkOutput("fx_valid", 32'(valid_fx), 32'(e.valid));
            checkOutput("fx_gnt", 32'(gnt_fx), 32'(e.gnt));
            checkOutput("fx_conflict", 32'(conf_fx), 32'(e.conflict));
            checkOutput("fx_cnt", 32'(cnt_fx), 32'(e.cnt));
        end
    endtask

    // Drive one cycle of inputs, queue the model's prediction, then check after the edge
    task automatic applyStimulus(input logic r, input logic [N-1:0] q,
                                 input logic [N*DW-1:0] d, input logic c);
        rst     = r;
        req     = q;
        data    = d;
        clr_cnt = c;
        m_rr = modelStep(m_rr, r, q, d, c, 1'b1);
        m_fx = modelStep(m_fx, r, q, d, c, 1'b0);
        q_rr.push_back(m_rr);
        q_fx.push_back(m_fx);
        @(posedge clk);
        #1;
        compareScoreboard();
    endtask

    initial begin
        logic [N*DW-1:0] rot_data;
        logic [N*DW-1:0] x_data;
        n_checks = 0;
        n_fail   = 0;
        m_rr     = '0;
        m_fx     = '0;
        rst      = 1'b1;
        req      = '0;
        data     = '0;
        clr_cnt  = 1'b0;
        rot_gnt  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        rot_out  = '{8'h00, 8'h11, 8'h33, 8'h00};
        rot_data = {8'h33, 8'h22, 8'h11, 8'h00};

        $display("[TB] reset");
        applyStimulus(1'b1, 4'b0000, '0, 1'b0);
        applyStimulus(1'b1, 4'b0000, '0, 1'b0);
        checkOutput("reset_gnt", 32'(gnt_rr), 32'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b0, 4'b0110, 32'h44332211, 1'b0);
        applyStimulus(1'b1, 4'b0110, 32'h44332211, 1'b0);
        checkOutput("midrst_out_q", 32'(out_q_rr), 32'd0);
        checkOutput("midrst_cnt", 32'(cnt_fx), 32'd0);
        checkOutput("midrst_ptr", 32'(dut_rr.ptr), 32'd0);

        $display("[TB] round-robin rotation");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b1011, rot_data, 1'b0);
            checkOutput("plan_rot_gnt", 32'(gnt_rr), 32'(rot_gnt[i]));
            checkOutput("plan_rot_out", 32'(out_q_rr), 32'(rot_out[i]));
        end

        $display("[TB] fixed priority");
        applyStimulus(1'b0, 4'b0000, rot_data, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 4'b1100, rot_data, 1'b0);
            checkOutput("plan_fx_gnt", 32'(gnt_fx), 32'b0100);
            checkOutput("plan_fx_out", 32'(out_q_fx), 32'h22);
        end
        checkOutput("plan_fx_cnt", 32'(cnt_fx), 32'd2);

        $display("[TB] idle hold");
        applyStimulus(1'b0, 4'b0001, 32'h000000A5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0000, 32'h5A5A5A5A, 1'b0);
        end
        checkOutput("plan_idle_out", 32'(out_q_rr), 32'hA5);

        $display("[TB] saturation and clear");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 4'b1111, 32'(i * 32'h01010101), 1'b0);
        end
        checkOutput("plan_sat_cnt", 32'(cnt_rr), 32'd15);
        applyStimulus(1'b0, 4'b1111, 32'h0, 1'b1);
        checkOutput("plan_clr_cnt", 32'(cnt_rr), 32'd0);
        checkOutput("plan_clr_conflict", 32'(conf_rr), 32'd1);

        $display("[TB] X isolation");
        x_data = {24'hxxxxxx, 8'h5A};
        applyStimulus(1'b0, 4'b0001, x_data, 1'b0);
        checkOutput("plan_x_out", 32'(out_q_fx), 32'h5A);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(($urandom_range(0, 29) == 0), N'($urandom), $urandom,
                          ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_source_arbiter.md
Name: multi_source_arbiter

Overview:
- Parametrised N-source arbitrated register. This is the single-driver replacement for a signal that several processes would otherwise drive.
- Each cycle, one requesting source wins. Its data is captured into one output register, so every net has exactly one driver.
- A saturating counter records multi-drive contention events, i.e. cycles with more than one requester.
- Selection logic is full and parallel: no overlapping or missing decode cases.

Parameters:
- N_SRC, 4, number of sources (2..16).
- DATA_W, 8, data width per source.
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round robin.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_SRC  per-source request; bit i asserted means source i wants to drive.
- data  input  N_SRC*DATA_W  packed source data; source i occupies bits [i*DATA_W +: DATA_W].
- clr_cnt  input  1  synchronous clear of the contention counter.
- out_q  output  DATA_W  arbitrated registered value.
- out_valid  output  1  high when out_q was updated this cycle.
- gnt  output  N_SRC  registered one-hot grant, aligned with out_valid.
- conflict  output  1  registered pulse, high when more than one req bit was set in the previous cycle.
- conflict_cnt  output  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_q=0, out_valid=0, gnt=0, conflict=0, conflict_cnt=0.
  - Round-robin pointer ptr=0.
  - Reset dominates every other input, including mid-arbitration. There is no partial update.
- Latency: req/data are sampled at edge t. out_q, gnt, out_valid and conflict reflect that sample after edge t (one cycle).
- Winner selection (combinational from sampled req):
  - MODE=0: lowest set index wins.
  - MODE=1: first set bit scanning upward from ptr, wrapping N_SRC-1 to 0.
- When req != 0:
  - out_q <= data of winner; gnt <= one-hot(winner); out_valid <= 1.
  - MODE=1 only: ptr <= (winner+1) mod N_SRC. Wrap when winner = N_SRC-1.
- When req == 0:
  - out_q holds; gnt <= 0; out_valid <= 0.
  - ptr unchanged.
- A single persistent requester wins every cycle in both modes. This is the starvation-free baseline.
- Contention:
  - conflict <= (popcount(req) > 1).
  - conflict_cnt increments by 1 on each such cycle and saturates at 2^CNT_W-1 (no wrap).
  - If clr_cnt=1 in the same cycle as a conflict, the clear wins: conflict_cnt <= 0. The conflict pulse is still emitted.
- Data of non-winners is ignored entirely. X on unused lanes must not propagate to out_q.
- No combinational path from any input to any output.
- MODE is static (elaboration-time). No run-time mode change.

Decomposition:
- Package multi_src_pkg:
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - A popcount-greater-than-one function shared with the bench.
- Sub-module rr_pick: combinational, parameter N.
  - Inputs: req, ptr.
  - Outputs: winner index and any-request flag.
  - Implemented as a double-width masked priority encoder.
  - MODE=0 ties ptr to 0.
- Top level holds the registers, pointer and counter only.

Test Plan (N_SRC=4, DATA_W=8, CNT_W=4 unless stated):
- Reset mid-stream: req=4'b0110, then rst=1 for 1 cycle with req still active.
  - Next cycle: out_q=0, gnt=0, out_valid=0, conflict_cnt=0, ptr=0.
- MODE=1 rotation: ptr=0, req=4'b1011 held for 3 cycles, data = {8'h33, 8'h22, 8'h11, 8'h00}.
  - Required gnt sequence: 0001, 0010, 1000; out_q sequence 00, 11, 33.
  - Fourth cycle: gnt=0001 again (wrap from 3 to 0).
- MODE=0 fixed priority: req=4'b1100 for 2 cycles.
  - gnt=0100 both cycles; out_q=data[2] both cycles.
  - conflict=1 both cycles; conflict_cnt reaches 2.
- Idle hold: one grant with out_q=8'hA5, then req=0 for 5 cycles.
  - out_q stays A5, out_valid=0, gnt=0, ptr unchanged.
- Saturation and clear:
  - 20 consecutive conflict cycles: conflict_cnt reaches 15 and stays there.
  - clr_cnt=1 together with a conflict: conflict_cnt=0, conflict=1.
- X isolation: req=4'b0001, data[1..3] driven X.
  - out_q equals data[0] with no X bits.
